// File: rtl/dvfs_pkg.sv
// Shared DVFS types, FSM encoding and the P-state to voltage-code mapping
// (also used by the utilisation classifier).
package dvfs_pkg;

    typedef logic [1:0] pstate_t;
    typedef logic [2:0] vcode_t;

    typedef enum logic [2:0] {
        IDLE,
        V_REQ,
        V_WAIT,
        F_SET,
        F_WAIT,
        DONE,
        FAULT
    } state_t;

    localparam pstate_t P_MAX_PERF = 2'd0;
    localparam pstate_t P_LOW_PWR  = 2'd3;

    function automatic vcode_t pstate_to_vcode(input pstate_t p);
        case (p)
            2'd0:    return 3'd7;
            2'd1:    return 3'd5;
            2'd2:    return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dvfs_settle_timer.sv
// Loadable down-counter shared by the ack timeout and both settle windows;
// holds at zero, where expired is asserted.
module dvfs_settle_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             expired
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - WIDTH'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Applies debounced, thermally capped P-state changes to the regulator and
// clock select: voltage before frequency going up, frequency first going down.
module dvfs_transition_sequencer #(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned V_SETTLE_CYCLES = 32,
    parameter int unsigned F_SETTLE_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_pstate,
    input  logic [1:0] thermal_cap,
    input  logic       vreg_ack,
    output logic [2:0] vreg_code,
    output logic       vreg_req,
    output logic [1:0] freq_sel,
    output logic [1:0] cur_pstate,
    output logic       busy,
    output logic       done,
    output logic       err
);
    import dvfs_pkg::*;

    localparam int unsigned TMAX_VF = (V_SETTLE_CYCLES > F_SETTLE_CYCLES) ? V_SETTLE_CYCLES
                                                                          : F_SETTLE_CYCLES;
    localparam int unsigned TMAX    = (TMAX_VF > ACK_TIMEOUT) ? TMAX_VF : ACK_TIMEOUT;
    localparam int unsigned CW      = $clog2(TMAX + 1);
    localparam int unsigned HW      = $clog2(HOLD_CYCLES + 1);

    // Timer is loaded with N-1 so a wait state occupies exactly N cycles.
    localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] V_LOAD   = CW'(V_SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] F_LOAD   = CW'(F_SETTLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    state_t          state, state_n;
    pstate_t         cand, cand_n;
    pstate_t         target, target_n;
    logic            dir_up, dir_up_n;
    logic [HW-1:0]   hold_cnt, hold_n, hold_inc;
    pstate_t         cur_n, freq_n;
    vcode_t          vcode_n;
    logic            err_n;
    pstate_t         tgt;

    logic            tmr_load;
    logic [CW-1:0]   tmr_load_value;
    logic [CW-1:0]   tmr_value;
    logic            tmr_expired;

    dvfs_settle_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value),
        .expired    (tmr_expired)
    );

    assign tgt = (req_pstate > thermal_cap) ? req_pstate : thermal_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= P_LOW_PWR;
            target     <= P_LOW_PWR;
            dir_up     <= 1'b0;
            hold_cnt   <= '0;
            cur_pstate <= P_LOW_PWR;
            freq_sel   <= P_LOW_PWR;
            vreg_code  <= pstate_to_vcode(P_LOW_PWR);
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cand       <= cand_n;
            target     <= target_n;
            dir_up     <= dir_up_n;
            hold_cnt   <= hold_n;
            cur_pstate <= cur_n;
            freq_sel   <= freq_n;
            vreg_code  <= vcode_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n        = state;
        cand_n         = cand;
        target_n       = target;
        dir_up_n       = dir_up;
        hold_n         = hold_cnt;
        hold_inc       = '0;
        cur_n          = cur_pstate;
        freq_n         = freq_sel;
        vcode_n        = vreg_code;
        err_n          = err;
        tmr_load       = 1'b0;
        tmr_load_value = '0;

        case (state)
            IDLE: begin
                if (tgt == cur_pstate) begin
                    hold_n = '0;
                end else begin
                    if (tgt == cand) begin
                        hold_inc = hold_cnt + HW'(1);
                    end else begin
                        cand_n   = tgt;
                        hold_inc = HW'(1);
                    end
                    hold_n = hold_inc;
                    if (hold_inc == HOLD_MAX) begin
                        target_n = tgt;
                        dir_up_n = (tgt < cur_pstate);
                        hold_n   = '0;
                        if (tgt < cur_pstate) begin
                            state_n        = V_REQ;
                            vcode_n        = pstate_to_vcode(tgt);
                            tmr_load       = 1'b1;
                            tmr_load_value = ACK_LOAD;
                        end else begin
                            state_n = F_SET;
                        end
                    end
                end
            end
            V_REQ: begin
                if (vreg_ack) begin
                    state_n        = V_WAIT;
                    tmr_load       = 1'b1;
                    tmr_load_value = V_LOAD;
                end else if (tmr_value == '0) begin
                    state_n = FAULT;
                    freq_n  = P_LOW_PWR;
                    cur_n   = P_LOW_PWR;
                    err_n   = 1'b1;
                end
            end
            V_WAIT: begin
                if (tmr_expired) begin
                    if (dir_up) begin
                        state_n = F_SET;
                    end else begin
                        state_n = DONE;
                        cur_n   = target;
                    end
                end
            end
            F_SET: begin
                freq_n         = target;
                state_n        = F_WAIT;
                tmr_load       = 1'b1;
                tmr_load_value = F_LOAD;
            end
            F_WAIT: begin
                if (tmr_expired) begin
                    if (dir_up) begin
                        state_n = DONE;
                        cur_n   = target;
                    end else begin
                        state_n        = V_REQ;
                        vcode_n        = pstate_to_vcode(target);
                        tmr_load       = 1'b1;
                        tmr_load_value = ACK_LOAD;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            FAULT: begin
                state_n = FAULT;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign vreg_req = (state == V_REQ);

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Directed bench for the DVFS sequencer: cycle-exact up/down sequencing,
// debounce, thermal cap, ack timeout and asynchronous reset mid-transition.
module tb_dvfs_transition_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_pstate = 2'd3;
    logic [1:0] thermal_cap = 2'd0;
    logic       vreg_ack = 1'b0;
    logic [2:0] vreg_code;
    logic       vreg_req;
    logic [1:0] freq_sel;
    logic [1:0] cur_pstate;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [2:0] acked_v;

    dvfs_transition_sequencer #(
        .HOLD_CYCLES     (16),
        .V_SETTLE_CYCLES (32),
        .F_SETTLE_CYCLES (8),
        .ACK_TIMEOUT     (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_pstate  (req_pstate),
        .thermal_cap (thermal_cap),
        .vreg_ack    (vreg_ack),
        .vreg_code   (vreg_code),
        .vreg_req    (vreg_req),
        .freq_sel    (freq_sel),
        .cur_pstate  (cur_pstate),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] vmap(input logic [1:0] p);
        return 3'd7 - {p, 1'b0};
    endfunction

    // Last voltage the regulator accepted; the running frequency must never need more.
    always @(posedge clk or posedge rst) begin
        if (rst) acked_v <= 3'd1;
        else if (vreg_req && vreg_ack) acked_v <= vreg_code;
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (vmap(freq_sel) > acked_v) begin
                errors++;
                $display("FAIL invariant_v_vs_f: freq_sel=%0d needs v=%0d, acked v=%0d",
                         freq_sel, vmap(freq_sel), acked_v);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        vreg_ack = 1'b0;
        req_pstate = 2'd3;
        thermal_cap = 2'd0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Answers vreg_req with an ack two cycles later; stops on done or on freq_sel==stop_freq.
    task automatic service(input int unsigned max_cyc, input int stop_freq, output bit hit,
                           output logic [1:0] min_freq, output logic [1:0] min_cur);
        int unsigned age = 0;
        hit = 1'b0;
        min_freq = freq_sel;
        min_cur = cur_pstate;
        for (int unsigned i = 0; i < max_cyc && !hit; i++) begin
            tick();
            if (freq_sel < min_freq) min_freq = freq_sel;
            if (cur_pstate < min_cur) min_cur = cur_pstate;
            if (done || int'(freq_sel) == stop_freq) hit = 1'b1;
            vreg_ack = 1'b0;
            if (vreg_req) begin
                age++;
                if (age >= 3) vreg_ack = 1'b1;
            end else begin
                age = 0;
            end
        end
        vreg_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_cur_pstate", cur_pstate, 3);
        chk("rst_freq_sel", freq_sel, 3);
        chk("rst_vreg_code", vreg_code, 1);
        chk("rst_vreg_req", vreg_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_up_scale();
        req_pstate = 2'd0;
        thermal_cap = 2'd0;
        repeat (15) tick();
        chk("up_busy_before_hold", busy, 0);
        tick();
        chk("up_busy_after_hold", busy, 1);
        chk("up_vreg_req", vreg_req, 1);
        chk("up_vreg_code", vreg_code, 7);
        chk("up_freq_before_ack", freq_sel, 3);
        repeat (2) tick();
        vreg_ack = 1'b1;
        tick();
        vreg_ack = 1'b0;
        chk("up_req_dropped", vreg_req, 0);
        repeat (32) tick();
        chk("up_freq_in_settle", freq_sel, 3);
        tick();
        chk("up_freq_switched", freq_sel, 0);
        repeat (7) tick();
        chk("up_done_early", done, 0);
        tick();
        chk("up_done_pulse", done, 1);
        chk("up_cur_pstate", cur_pstate, 0);
        tick();
        chk("up_done_one_cycle", done, 0);
        chk("up_idle", busy, 0);
    endtask

    task automatic test_down_scale();
        req_pstate = 2'd3;
        repeat (15) tick();
        chk("dn_busy_before_hold", busy, 0);
        tick();
        chk("dn_busy_after_hold", busy, 1);
        chk("dn_no_vreq_first", vreg_req, 0);
        tick();
        chk("dn_freq_first", freq_sel, 3);
        chk("dn_vcode_unchanged", vreg_code, 7);
        repeat (7) tick();
        chk("dn_vreq_early", vreg_req, 0);
        tick();
        chk("dn_vreq", vreg_req, 1);
        chk("dn_vcode", vreg_code, 1);
        repeat (2) tick();
        vreg_ack = 1'b1;
        tick();
        vreg_ack = 1'b0;
        repeat (31) tick();
        chk("dn_done_early", done, 0);
        tick();
        chk("dn_done_pulse", done, 1);
        chk("dn_cur_pstate", cur_pstate, 3);
    endtask

    task automatic test_debounce();
        bit saw_busy = 1'b0;
        bit hit;
        logic [1:0] mf, mc;
        tick();
        for (int seg = 0; seg < 20; seg++) begin
            req_pstate = (seg % 2 == 0) ? 2'd2 : 2'd1;
            repeat (5) begin
                tick();
                if (busy) saw_busy = 1'b1;
            end
        end
        chk("deb_no_busy_while_toggling", saw_busy, 0);
        req_pstate = 2'd2;
        repeat (15) tick();
        chk("deb_busy_before_hold", busy, 0);
        tick();
        chk("deb_busy_at_hold", busy, 1);
        chk("deb_vcode", vreg_code, 3);
        service(300, -1, hit, mf, mc);
        chk("deb_done_seen", hit, 1);
        chk("deb_cur_pstate", cur_pstate, 2);
        chk("deb_freq_sel", freq_sel, 2);
    endtask

    task automatic test_thermal_cap();
        bit hit;
        logic [1:0] mf, mc;
        apply_reset();
        req_pstate = 2'd0;
        thermal_cap = 2'd2;
        service(300, -1, hit, mf, mc);
        chk("cap_done_seen", hit, 1);
        chk("cap_cur_pstate", cur_pstate, 2);
        chk("cap_freq_sel", freq_sel, 2);
        chk("cap_vcode", vreg_code, 3);
        chk("cap_min_freq", mf, 2);
        chk("cap_min_cur", mc, 2);
        repeat (40) tick();
        chk("cap_stays_idle", busy, 0);
    endtask

    task automatic test_timeout();
        apply_reset();
        req_pstate = 2'd0;
        thermal_cap = 2'd0;
        repeat (16) tick();
        chk("to_vreq", vreg_req, 1);
        repeat (63) tick();
        chk("to_err_early", err, 0);
        chk("to_vreq_held", vreg_req, 1);
        tick();
        chk("to_err", err, 1);
        chk("to_freq_sel", freq_sel, 3);
        chk("to_vreq_dropped", vreg_req, 0);
        chk("to_busy", busy, 1);
        chk("to_vcode_held", vreg_code, 7);
        chk("to_cur_pstate", cur_pstate, 3);
        vreg_ack = 1'b1;
        repeat (10) tick();
        vreg_ack = 1'b0;
        tick();
        chk("to_late_ack_err", err, 1);
        chk("to_late_ack_busy", busy, 1);
        chk("to_late_ack_freq", freq_sel, 3);
        chk("to_late_ack_done", done, 0);
    endtask

    task automatic test_reset_mid();
        bit hit;
        logic [1:0] mf, mc;
        apply_reset();
        chk("rm_err_cleared", err, 0);
        req_pstate = 2'd0;
        service(300, 0, hit, mf, mc);
        chk("rm_reached_f_wait", hit, 1);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rm_freq_sel", freq_sel, 3);
        chk("rm_vcode", vreg_code, 1);
        chk("rm_busy", busy, 0);
        chk("rm_vreq", vreg_req, 0);
        chk("rm_cur", cur_pstate, 3);
        chk("rm_done", done, 0);
        req_pstate = 2'd1;
        tick();
        rst = 1'b0;
        service(300, -1, hit, mf, mc);
        chk("rm_new_done_seen", hit, 1);
        chk("rm_new_cur", cur_pstate, 1);
        chk("rm_new_freq", freq_sel, 1);
        chk("rm_new_vcode", vreg_code, 5);
    endtask

    initial begin
        test_reset();
        test_up_scale();
        test_down_scale();
        test_debounce();
        test_thermal_cap();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "watchdog");
    end

endmodule
